// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter driving the register-file write port, plus a
// destination scoreboard that marks registers reserved at issue until they commit.
module regfile_wb_arbiter #(
    parameter int NUM_SRC = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    output logic [NUM_SRC-1:0]    src_ready_o,
    input  logic [5*NUM_SRC-1:0]  src_rd_i,
    input  logic [32*NUM_SRC-1:0] src_data_i,
    input  logic                  rsv_valid_i,
    input  logic [4:0]            rsv_rd_i,
    input  logic                  flush_i,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [31:0]           rf_wdata_o,
    output logic [31:0]           busy_o
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(NUM_SRC);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]       busy_q, busy_d;

    logic [NUM_SRC-1:0] grant;
    logic [PTR_W-1:0]   win_idx;
    logic               any_valid;
    logic [4:0]         win_rd;
    logic [DATA_W-1:0]  win_data;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        if (idx == PTR_W'(NUM_SRC - 1)) begin
            return '0;
        end
        return idx + PTR_W'(1);
    endfunction

    // Scan ptr, ptr+1, ... modulo NUM_SRC; the first valid source wins.
    always_comb begin
        int idx;
        grant     = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!any_valid && src_valid_i[idx]) begin
                any_valid   = 1'b1;
                grant[idx]  = 1'b1;
                win_idx     = idx[PTR_W-1:0];
            end
        end
    end

    assign src_ready_o = grant;
    assign win_rd      = src_rd_i[5*win_idx +: 5];
    assign win_data    = src_data_i[DATA_W*win_idx +: DATA_W];

    always_comb begin
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (any_valid) begin
            ptr_d      = next_ptr(win_idx);
            rf_we_d    = (win_rd != 5'd0);
            rf_waddr_d = win_rd;
            rf_wdata_d = win_data;
        end
    end

    // Clear is applied before set so a fresh reservation of the committing register survives.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (rsv_valid_i && (rsv_rd_i != 5'd0)) begin
            busy_d[rsv_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with NUM_SRC=3 and hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  src_valid;
    logic [N-1:0]  src_ready;
    logic [5*N-1:0]  src_rd;
    logic [32*N-1:0] src_data;
    logic          rsv_valid;
    logic [4:0]    rsv_rd;
    logic          flush;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [31:0]   busy;

    int n_vec;
    int n_err;

    regfile_wb_arbiter #(.NUM_SRC(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .src_rd_i   (src_rd),
        .src_data_i (src_data),
        .rsv_valid_i(rsv_valid),
        .rsv_rd_i   (rsv_rd),
        .flush_i    (flush),
        .rf_we_o    (rf_we),
        .rf_waddr_o (rf_waddr),
        .rf_wdata_o (rf_wdata),
        .busy_o     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        src_valid[i]        = v;
        src_rd[5*i +: 5]    = rd;
        src_data[32*i +: 32] = d;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        src_valid = '0;
        src_rd = '0;
        src_data = '0;
        rsv_valid = 1'b0;
        rsv_rd = '0;
        flush = 1'b0;

        #12;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_busy", busy, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single source
        set_src(2, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_ready", {29'd0, src_ready}, 32'b100);
        tick();
        set_src(2, 1'b0, 5'd5, 32'hDEADBEEF);
        check("single_we", {31'd0, rf_we}, 32'd1);
        check("single_waddr", {27'd0, rf_waddr}, 32'd5);
        check("single_wdata", rf_wdata, 32'hDEADBEEF);

        // Round-robin, ptr is now 0
        set_src(0, 1'b1, 5'd1, 32'h1111_0000);
        set_src(1, 1'b1, 5'd2, 32'h2222_0000);
        set_src(2, 1'b1, 5'd3, 32'h3333_0000);
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_ready", {29'd0, src_ready}, 32'd1 << (c % 3));
            tick();
            check("rr_we", {31'd0, rf_we}, 32'd1);
            check("rr_waddr", {27'd0, rf_waddr}, 32'((c % 3) + 1));
        end
        check("rr_wdata", rf_wdata, 32'h3333_0000);
        src_valid = '0;
        #1;
        check("idle_ready", {29'd0, src_ready}, 32'd0);
        tick();
        check("idle_we", {31'd0, rf_we}, 32'd0);
        check("idle_waddr_hold", {27'd0, rf_waddr}, 32'd3);

        // x0 write, ptr is 0
        set_src(0, 1'b1, 5'd0, 32'hABCD_0000);
        #1;
        check("x0_ready", {29'd0, src_ready}, 32'b001);
        tick();
        set_src(0, 1'b0, 5'd0, 32'h0);
        check("x0_we", {31'd0, rf_we}, 32'd0);
        check("x0_busy", busy, 32'd0);

        // Reserve x7 then commit it through src1 (ptr is 1)
        rsv_valid = 1'b1;
        rsv_rd = 5'd7;
        tick();
        rsv_valid = 1'b0;
        check("rsv7_busy", busy, 32'h0000_0080);
        set_src(1, 1'b1, 5'd7, 32'h0000_0777);
        #1;
        check("wb7_ready", {29'd0, src_ready}, 32'b010);
        tick();
        set_src(1, 1'b0, 5'd7, 32'h0);
        check("wb7_we", {31'd0, rf_we}, 32'd1);
        check("wb7_busy_still", busy, 32'h0000_0080);
        tick();
        check("wb7_busy_clr", busy, 32'd0);
        check("wb7_we_off", {31'd0, rf_we}, 32'd0);

        // Re-reserve x7 while its previous write commits (ptr is 2)
        rsv_valid = 1'b1;
        rsv_rd = 5'd7;
        tick();
        rsv_valid = 1'b0;
        set_src(2, 1'b1, 5'd7, 32'h0000_7777);
        tick();
        set_src(2, 1'b0, 5'd7, 32'h0);
        check("rerv_we", {31'd0, rf_we}, 32'd1);
        check("rerv_waddr", {27'd0, rf_waddr}, 32'd7);
        rsv_valid = 1'b1;
        rsv_rd = 5'd7;
        tick();
        rsv_valid = 1'b0;
        check("rerv_busy_kept", busy, 32'h0000_0080);

        // Flush with an in-flight write to x3 (ptr is 0)
        rsv_valid = 1'b1;
        rsv_rd = 5'd3;
        tick();
        rsv_rd = 5'd9;
        tick();
        rsv_valid = 1'b0;
        check("pre_flush_busy", busy, 32'h0000_0288);
        set_src(0, 1'b1, 5'd3, 32'h0000_0333);
        flush = 1'b1;
        rsv_valid = 1'b1;
        rsv_rd = 5'd4;
        tick();
        flush = 1'b0;
        rsv_valid = 1'b0;
        set_src(0, 1'b0, 5'd3, 32'h0);
        check("flush_busy", busy, 32'd0);
        check("flush_we", {31'd0, rf_we}, 32'd1);
        check("flush_waddr", {27'd0, rf_waddr}, 32'd3);

        // Asynchronous reset mid-traffic (ptr is 1)
        set_src(1, 1'b1, 5'd12, 32'hC0FF_EE12);
        rsv_valid = 1'b1;
        rsv_rd = 5'd10;
        tick();
        rsv_valid = 1'b0;
        set_src(0, 1'b1, 5'd20, 32'h2020_2020);
        set_src(2, 1'b1, 5'd22, 32'h2222_2222);
        check("pre_rst_we", {31'd0, rf_we}, 32'd1);
        check("pre_rst_busy", busy, 32'h0000_0400);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'd0, rf_we}, 32'd0);
        check("arst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("arst_wdata", rf_wdata, 32'd0);
        check("arst_busy", busy, 32'd0);
        check("arst_ready", {29'd0, src_ready}, 32'b001);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_we", {31'd0, rf_we}, 32'd1);
        check("post_rst_waddr", {27'd0, rf_waddr}, 32'd20);
        check("post_rst_wdata", rf_wdata, 32'h2020_2020);
        src_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
